// File: rtl/ctl_word_sequencer.sv
// JTAG control-word FIFO plus executor driving a valid/ready local-bus write port.
// Optional CTL_SEQ_TIMEOUT_EN adds a WAIT stall timeout and sticky timeout flag.
module ctl_word_sequencer #(
  parameter int AW    = 16,
  parameter int DEPTH = 4,
  parameter int TMO   = 1024
) (
  input  logic                     usbclk,
  input  logic                     rst,
  input  logic [39:0]              control_bus,
  input  logic                     control_strobe,
  output logic [AW-1:0]            lb_addr,
  output logic [31:0]              lb_data,
  output logic                     lb_write,
  input  logic                     lb_ready,
  output logic                     overflow,
  output logic                     busy,
`ifdef CTL_SEQ_TIMEOUT_EN
  output logic                     timeout,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  if (AW < 8 || AW > 24 || DEPTH < 2 || DEPTH > 16 ||
      (DEPTH & (DEPTH - 1)) != 0 || TMO < 1) begin : g_bad_cfg
    $error("ctl_word_sequencer: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } state_t;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SETPTR = 2'b01;
  localparam logic [1:0] OP_BURST  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  logic [39:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [LW-1:0] level_q;
  state_t        state_q;
  logic [39:0]   cmd_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          write_q;
  logic          ovf_q;

`ifdef CTL_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] tcnt_q;
  logic          tmo_q;
`endif

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [1:0] op;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = control_strobe & ~full;
  assign pop   = (state_q == S_IDLE) & ~empty;
  assign op    = cmd_q[39:38];

  always_ff @(posedge usbclk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      state_q <= S_IDLE;
      cmd_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef CTL_SEQ_TIMEOUT_EN
      tcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      if (push) begin
        mem_q[wr_q] <= control_bus;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      level_q <= level_q + LW'(push) - LW'(pop);

      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            cmd_q   <= mem_q[rd_q];
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          unique case (op)
            OP_SETPTR: begin
              ptr_q   <= cmd_q[AW-1:0];
              state_q <= S_IDLE;
            end
            OP_CLEAR: begin
              ptr_q   <= '0;
              ovf_q   <= 1'b0;
`ifdef CTL_SEQ_TIMEOUT_EN
              tmo_q   <= 1'b0;
`endif
              state_q <= S_IDLE;
            end
            OP_WRITE: begin
              addr_q  <= {{(AW-6){1'b0}}, cmd_q[37:32]};
              data_q  <= cmd_q[31:0];
              write_q <= 1'b1;
              state_q <= S_WAIT;
`ifdef CTL_SEQ_TIMEOUT_EN
              tcnt_q  <= '0;
`endif
            end
            default: begin
              addr_q  <= ptr_q;
              data_q  <= cmd_q[31:0];
              write_q <= 1'b1;
              state_q <= S_WAIT;
`ifdef CTL_SEQ_TIMEOUT_EN
              tcnt_q  <= '0;
`endif
            end
          endcase
        end
        S_WAIT: begin
          if (lb_ready) begin
            write_q <= 1'b0;
            state_q <= S_IDLE;
            if (op == OP_BURST) begin
              ptr_q <= ptr_q + 1'b1;
            end
`ifdef CTL_SEQ_TIMEOUT_EN
          end else if (tcnt_q == CW'(TMO - 1)) begin
            // stalled sink: drop the command, pointer stays put
            write_q <= 1'b0;
            tmo_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // a dropped word wins over a same-cycle CLEAR
      if (control_strobe && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign lb_addr  = addr_q;
  assign lb_data  = data_q;
  assign lb_write = write_q;
  assign overflow = ovf_q;
  assign level    = level_q;
  assign busy     = ~empty | (state_q != S_IDLE);
`ifdef CTL_SEQ_TIMEOUT_EN
  assign timeout  = tmo_q;
`endif

endmodule

// File: doc/ctl_word_sequencer.md
Name: ctl_word_sequencer

Overview:
- Consumes the 40-bit control word and single-cycle strobe produced by the JTAG control interface, in the usbclk domain.
- Buffers words in a small FIFO and decodes each into local-bus writes, with single-address and auto-increment (burst) modes.
- Drives a valid/ready local-bus write port, so a stalling register file never loses JTAG-issued commands.

Parameters:
- AW, 16, local-bus address and auto-increment pointer width (8..24)
- DEPTH, 4, command FIFO depth in words; power of two, 2..16
- TMO, 1024, stall timeout in cycles (used only with the optional feature)

Ports:
- usbclk  input  1  sole clock
- rst  input  1  synchronous, active-high reset
- control_bus  input  40  command word, valid when control_strobe high
- control_strobe  input  1  one-cycle push request
- lb_addr  output  AW  write address
- lb_data  output  32  write data
- lb_write  output  1  write valid; held until accepted
- lb_ready  input  1  sink accepts when lb_write & lb_ready at a clock edge
- overflow  output  1  sticky: a strobe arrived while the FIFO was full
- busy  output  1  FIFO non-empty or executor not IDLE
- level  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Word format: op = [39:38], a6 = [37:32], d = [31:0].
  - op 00 WRITE: lb_addr = zero-extended a6, lb_data = d.
  - op 01 SETPTR: ptr <= d[AW-1:0]; no bus cycle.
  - op 10 BURST: lb_addr = ptr, lb_data = d; ptr increments by 1 on acceptance, wrapping from 2^AW-1 to 0.
  - op 11 CLEAR: ptr <= 0, overflow <= 0; no bus cycle; FIFO contents untouched.
- Push: on a clock edge with control_strobe=1:
  - FIFO not full: control_bus is written and level increments.
  - FIFO full: word dropped, overflow <= 1, FIFO unchanged. A pop in the same cycle does not rescue the word.
- Simultaneous push and pop with the FIFO neither full nor empty: level unchanged.
- Executor states: IDLE, LOAD, WAIT.
  - IDLE: FIFO non-empty -> pop the head into the command register, go to LOAD.
  - LOAD: ops 01/11 update state and return to IDLE; ops 00/10 drive lb_addr/lb_data, set lb_write=1, go to WAIT.
  - WAIT: hold lb_write, lb_addr and lb_data stable until lb_ready=1 at an edge, then lb_write <= 0 and return to IDLE.
- Latency: a strobe into an empty FIFO with an IDLE executor gives lb_write high 3 edges later (push, pop/LOAD, output register).
- Throughput: one bus write per 3 cycles when lb_ready is held high.
- lb_ready is ignored whenever lb_write=0.
- Reset values: lb_write=0, lb_addr=0, lb_data=0, overflow=0, busy=0, level=0, ptr=0, state IDLE, FIFO empty.
- Reset takes effect at the next edge even in WAIT. Any pending bus write is abandoned and the sink must not count it.
- A strobe in the same cycle as rst is ignored.

Optional Feature:
- Macro: CTL_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs while in WAIT with lb_ready=0.
  - When it reaches TMO, lb_write <= 0, the command is discarded (ptr not incremented), the executor returns to IDLE, and sticky output timeout (1 bit, reset 0) is set.
  - op 11 clears timeout. The counter clears on every entry to WAIT.
- Not defined:
  - No timeout port and no counter; WAIT holds indefinitely.

Test Plan:
- WRITE {00, a6=0x05, d=0xDEADBEEF} with lb_ready=1 -> exactly one lb_write pulse 3 cycles after the strobe, lb_addr=0x0005, lb_data=0xDEADBEEF; busy then returns to 0.
- SETPTR d=0xFFFE, then three BURST words 0x11, 0x22, 0x33 -> writes land at 0xFFFE, 0xFFFF, 0x0000 in order; ptr ends at 0x0001.
- Hold lb_ready=0, issue 6 WRITE strobes (DEPTH=4) -> level peaks at 4 (1 word in the executor, 4 buffered, 1 dropped), overflow=1. Release ready -> exactly 5 writes in issue order. A later CLEAR -> overflow=0.
- Assert rst for one cycle while in WAIT with lb_ready=0 -> next cycle lb_write=0, level=0, overflow=0. After release, no stale write appears.
- Back-to-back strobes every cycle, 4 words, lb_ready random 50% -> all 4 writes in order; lb_addr/lb_data never change while lb_write=1 and lb_ready=0.
- With CTL_SEQ_TIMEOUT_EN and TMO=16: lb_ready stuck at 0 -> lb_write drops 16 cycles after entering WAIT, timeout=1, and the next queued command executes normally.
